// File: rtl/pulse_generator_prog_if.sv
// Control/status bundle for pulse_generator_prog: run controls in, pulse and status out.
// All controls are plain levels sampled on clk; there is no valid/ready handshake on this bus.
interface pulse_generator_prog_if #(
  parameter int RATE_W = 12,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              pause;
  logic [1:0]        mode;
  logic [RATE_W-1:0] rate;
  logic [CNT_W-1:0]  burst_n;
  logic              pulse;
  logic [CNT_W-1:0]  pulse_cnt;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  modport master (
    output start, pause, mode, rate, burst_n,
    input  pulse, pulse_cnt, busy, done, state_dbg
  );

  modport slave (
    input  start, pause, mode, rate, burst_n,
    output pulse, pulse_cnt, busy, done, state_dbg
  );
endinterface

// File: rtl/pulse_generator_prog.sv
// Programmable step-pulse source: phase-accumulator rate generator with continuous,
// counted-burst and ramp profiles, pause, busy/done status and a saturating pulse count.
module pulse_generator_prog #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int RATE_W    = 12,
  parameter int CNT_W     = 16,
  parameter int PULSE_LEN = 1
) (
  input logic                   clk,
  input logic                   reset,
  pulse_generator_prog_if.slave bus
);
  localparam int ACC_W = $clog2(CLK_HZ + 2**RATE_W);
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int STR_W = $clog2(PULSE_LEN + 1);

  localparam logic [ACC_W-1:0]  CLK_HZ_A = ACC_W'(CLK_HZ);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STR_W-1:0]  STR_LOAD = STR_W'(PULSE_LEN);
  localparam logic [STR_W-1:0]  STR_ONE  = STR_W'(1);
  localparam logic [1:0]        MODE_BURST = 2'b01;
  localparam logic [1:0]        MODE_RAMP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic [RATE_W-1:0] eff, ramp_eff;
  logic [RATE_W:0]   ramp_sum;
  logic [SEC_W-1:0]  sec_cnt;
  logic [STR_W-1:0]  str_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  burst_q;
  logic              done_q;
  logic              launch;
  logic              advance;
  logic              burst_full;
  logic              event_fire;
  logic              sec_wrap;

  // Datapath decode; the accumulator only advances in an unpaused, still-requested run.
  always_comb begin
    advance    = (state == RUN) && bus.start && !bus.pause;
    burst_full = (mode_q == MODE_BURST) && (cnt == burst_q);
    acc_sum    = acc + ACC_W'(eff);
    event_fire = advance && !burst_full && (acc_sum >= CLK_HZ_A);
    sec_wrap   = advance && (sec_cnt == SEC_LAST);
    ramp_sum   = {1'b0, eff} + {1'b0, bus.rate};
    ramp_eff   = ramp_sum[RATE_W] ? RATE_MAX : ramp_sum[RATE_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = ((bus.mode == MODE_BURST) && (bus.burst_n == '0)) ? FINISH : RUN;
        end
      end
      RUN: begin
        // Leave for FINISH as the last burst pulse drops, so DONE follows it directly.
        if (!bus.start)                              state_nxt = IDLE;
        else if (burst_full && (str_cnt <= STR_ONE)) state_nxt = FINISH;
      end
      FINISH: begin
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      eff     <= '0;
      sec_cnt <= '0;
      str_cnt <= '0;
      cnt     <= '0;
      mode_q  <= '0;
      burst_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_nxt == FINISH) && (state != FINISH);
      if (launch) begin
        mode_q  <= bus.mode;
        burst_q <= bus.burst_n;
        acc     <= '0;
        sec_cnt <= '0;
        cnt     <= '0;
        eff     <= bus.rate;
        str_cnt <= '0;
      end else if ((state == RUN) && !bus.start) begin
        str_cnt <= '0;
      end else begin
        if (advance && !burst_full) begin
          acc     <= event_fire ? (acc_sum - CLK_HZ_A) : acc_sum;
          sec_cnt <= sec_wrap ? '0 : (sec_cnt + SEC_W'(1));
          if (mode_q == MODE_RAMP) begin
            if (sec_wrap) eff <= ramp_eff;
          end else begin
            eff <= bus.rate;
          end
        end
        // A new event while the pulse is still high simply restarts the stretch.
        if (event_fire) begin
          str_cnt <= STR_LOAD;
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end else if (str_cnt != '0) begin
          str_cnt <= str_cnt - STR_W'(1);
        end
      end
    end
  end

  assign bus.pulse     = (str_cnt != '0);
  assign bus.pulse_cnt = cnt;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_pulse_generator_prog.sv
// Bench for pulse_generator_prog: three parameterisations, pulse-rise scoreboard on the main one.
module tb_pulse_generator_prog;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pulse_generator_prog_if #(.RATE_W(12), .CNT_W(16)) bus1();
  pulse_generator_prog_if #(.RATE_W(8),  .CNT_W(4))  bus2();
  pulse_generator_prog_if #(.RATE_W(8),  .CNT_W(16)) bus3();

  pulse_generator_prog #(.CLK_HZ(1000), .RATE_W(12), .CNT_W(16), .PULSE_LEN(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  pulse_generator_prog #(.CLK_HZ(500), .RATE_W(8), .CNT_W(4), .PULSE_LEN(3))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));
  pulse_generator_prog #(.CLK_HZ(500), .RATE_W(8), .CNT_W(16), .PULSE_LEN(1))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every rising edge of bus1.pulse must match the next expected cycle.
  task automatic monitor_loop();
    logic prev_pulse;
    logic [31:0] exp_c;
    prev_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (bus1.pulse === 1'b1 && prev_pulse === 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pulse_rise: rise at cycle %0d, expected no pulse", cyc);
        end else begin
          exp_c = exp_q.pop_front();
          if (cyc !== exp_c) begin
            n_fail++;
            $display("FAIL sb_pulse_rise: rise at cycle %0d, expected cycle %0d", cyc, exp_c);
          end
        end
      end
      prev_pulse = bus1.pulse;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus1.pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b, expected 0", bus1.pulse); end
    n_checks++; if (bus1.pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, expected 0", bus1.pulse_cnt); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus1.busy); end
    n_checks++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", bus1.done); end
    n_checks++; if (bus1.state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", bus1.state_dbg); end
    n_checks++; if (bus2.pulse_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d, expected 0", bus2.pulse_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    logic [31:0] t0;
    bus1.mode = 2'b00; bus1.rate = 12'd100; bus1.start = 1'b1; t0 = cyc;
    for (int k = 1; k <= 5; k++) exp_q.push_back(t0 + 10 * k + 1);
    for (int c = 1; c <= 51; c++) begin
      tick();
      n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy: cycle %0d got %b, expected 1", c, bus1.busy); end
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd5) begin n_fail++; $display("FAIL cont_cnt: got %0d, expected 5", bus1.pulse_cnt); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (bus1.pulse !== 1'b0) begin n_fail++; $display("FAIL cont_stop_pulse: got %b, expected 0", bus1.pulse); end
    n_checks++; if (bus1.pulse_cnt !== 16'd5) begin n_fail++; $display("FAIL cont_stop_cnt: got %0d, expected 5", bus1.pulse_cnt); end
    n_checks++; if (bus1.state_dbg !== 2'd0) begin n_fail++; $display("FAIL cont_stop_state: got %0d, expected 0", bus1.state_dbg); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_burst();
    logic [31:0] t0;
    bus1.mode = 2'b01; bus1.rate = 12'd250; bus1.burst_n = 16'd3; bus1.start = 1'b1; t0 = cyc;
    exp_q.push_back(t0 + 5); exp_q.push_back(t0 + 9); exp_q.push_back(t0 + 13);
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_checks++; if (bus1.done !== (c == 14)) begin n_fail++; $display("FAIL burst_done: cycle %0d got %b, expected %b", c, bus1.done, (c == 14)); end
      n_checks++; if (bus1.busy !== (c < 14)) begin n_fail++; $display("FAIL burst_busy: cycle %0d got %b, expected %b", c, bus1.busy, (c < 14)); end
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL burst_cnt: got %0d, expected 3", bus1.pulse_cnt); end
    n_checks++; if (bus1.state_dbg !== 2'd2) begin n_fail++; $display("FAIL burst_finish: got %0d, expected 2", bus1.state_dbg); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (bus1.state_dbg !== 2'd0) begin n_fail++; $display("FAIL burst_rearm: got %0d, expected 0", bus1.state_dbg); end
    bus1.burst_n = 16'd0; bus1.start = 1'b1;
    tick();
    n_checks++; if (bus1.done !== 1'b1) begin n_fail++; $display("FAIL burst0_done: got %b, expected 1", bus1.done); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL burst0_busy: got %b, expected 0", bus1.busy); end
    n_checks++; if (bus1.pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL burst0_cnt: got %0d, expected 0", bus1.pulse_cnt); end
    tick();
    n_checks++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL burst0_done_end: got %b, expected 0", bus1.done); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ramp();
    logic [31:0] t0;
    bus1.mode = 2'b10; bus1.rate = 12'd100; bus1.start = 1'b1; t0 = cyc;
    for (int k = 1; k <= 100; k++) exp_q.push_back(t0 + 10 * k + 1);
    for (int k = 1; k <= 200; k++) exp_q.push_back(t0 + 1000 + 5 * k + 1);
    for (int c = 1; c <= 2001; c++) begin
      tick();
      if (c == 1001) begin
        n_checks++; if (bus1.pulse_cnt !== 16'd100) begin n_fail++; $display("FAIL ramp_sec1: got %0d, expected 100", bus1.pulse_cnt); end
      end
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd300) begin n_fail++; $display("FAIL ramp_sec2: got %0d, expected 300", bus1.pulse_cnt); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ramp_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_pause();
    logic [31:0] t0;
    bus1.mode = 2'b00; bus1.rate = 12'd100; bus1.start = 1'b1; t0 = cyc;
    exp_q.push_back(t0 + 11); exp_q.push_back(t0 + 21);
    exp_q.push_back(t0 + 71); exp_q.push_back(t0 + 81);
    for (int c = 1; c <= 85; c++) begin
      tick();
      if (c > 25 && c <= 65) begin
        n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL pause_busy: cycle %0d got %b, expected 1", c, bus1.busy); end
      end
      if (c == 25) bus1.pause = 1'b1;
      if (c == 65) bus1.pause = 1'b0;
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd4) begin n_fail++; $display("FAIL pause_cnt: got %0d, expected 4", bus1.pulse_cnt); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pause_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_rate_zero();
    bus1.mode = 2'b00; bus1.rate = 12'd0; bus1.start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL rate0_busy: cycle %0d got %b, expected 1", c, bus1.busy); end
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL rate0_cnt: got %0d, expected 0", bus1.pulse_cnt); end
    bus1.start = 1'b0;
    tick();
  endtask

  task automatic test_rate_change();
    logic [31:0] t0;
    bus1.mode = 2'b00; bus1.rate = 12'd100; bus1.start = 1'b1; t0 = cyc;
    exp_q.push_back(t0 + 11); exp_q.push_back(t0 + 21);
    for (int k = 0; k < 7; k++) exp_q.push_back(t0 + 27 + 2 * k);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 25) bus1.rate = 12'd500;
    end
    n_checks++; if (bus1.pulse_cnt !== 16'd9) begin n_fail++; $display("FAIL ratechg_cnt: got %0d, expected 9", bus1.pulse_cnt); end
    bus1.start = 1'b0;
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ratechg_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] t0;
    bus1.mode = 2'b01; bus1.rate = 12'd250; bus1.burst_n = 16'd3; bus1.start = 1'b1; t0 = cyc;
    exp_q.push_back(t0 + 5); exp_q.push_back(t0 + 9);
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus1.pulse !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b, expected 0", bus1.pulse); end
    n_checks++; if (bus1.pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d, expected 0", bus1.pulse_cnt); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", bus1.busy); end
    n_checks++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b, expected 0", bus1.done); end
    bus1.start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++; if (bus1.done !== 1'b0 || bus1.state_dbg !== 2'd0) begin n_fail++; $display("FAIL rstmid_after: done %b state %0d, expected 0/0", bus1.done, bus1.state_dbg); end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_missing: %0d pulses not seen, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_saturation_retrigger();
    int highs;
    bus2.mode = 2'b00; bus2.rate = 8'd250; bus2.start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      n_checks++; if (bus2.pulse !== (c >= 3)) begin n_fail++; $display("FAIL retrig_pulse: cycle %0d got %b, expected %b", c, bus2.pulse, (c >= 3)); end
      if (c == 21) begin
        n_checks++; if (bus2.pulse_cnt !== 4'd10) begin n_fail++; $display("FAIL retrig_cnt: got %0d, expected 10", bus2.pulse_cnt); end
      end
    end
    n_checks++; if (bus2.pulse_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d, expected 15", bus2.pulse_cnt); end
    bus2.start = 1'b0;
    tick();
    n_checks++; if (bus2.pulse !== 1'b0) begin n_fail++; $display("FAIL sat_stop_pulse: got %b, expected 0", bus2.pulse); end
    bus2.rate = 8'd100; bus2.start = 1'b1; highs = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus2.pulse === 1'b1) highs++;
    end
    n_checks++; if (highs != 9) begin n_fail++; $display("FAIL stretch_len: %0d high cycles, expected 9", highs); end
    n_checks++; if (bus2.pulse_cnt !== 4'd3) begin n_fail++; $display("FAIL stretch_cnt: got %0d, expected 3", bus2.pulse_cnt); end
    bus2.start = 1'b0;
    tick();
  endtask

  task automatic test_ramp_saturation();
    bus3.mode = 2'b10; bus3.rate = 8'd200; bus3.start = 1'b1;
    for (int c = 1; c <= 1001; c++) begin
      tick();
      if (c == 501) begin
        n_checks++; if (bus3.pulse_cnt !== 16'd200) begin n_fail++; $display("FAIL rampsat_sec1: got %0d, expected 200", bus3.pulse_cnt); end
      end
    end
    n_checks++; if (bus3.pulse_cnt !== 16'd455) begin n_fail++; $display("FAIL rampsat_sec2: got %0d, expected 455", bus3.pulse_cnt); end
    bus3.start = 1'b0;
    tick();
  endtask

  initial begin
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.mode = 2'b00; bus1.rate = '0; bus1.burst_n = '0;
    bus2.start = 1'b0; bus2.pause = 1'b0; bus2.mode = 2'b00; bus2.rate = '0; bus2.burst_n = '0;
    bus3.start = 1'b0; bus3.pause = 1'b0; bus3.mode = 2'b00; bus3.rate = '0; bus3.burst_n = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_continuous();
    test_burst();
    test_ramp();
    test_pause();
    test_rate_zero();
    test_rate_change();
    test_reset_mid_burst();
    test_saturation_retrigger();
    test_ramp_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
